// File: rtl/matrix_loader_pkg.sv
// Shared types and sizing helpers for the matrix loader.
// Only the word count per matrix depends on N, so it is exposed as a function of N.
package matrix_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PTR_RST,
    LOAD_WEST,
    LOAD_NORTH,
    START,
    WAIT_DONE,
    FINISH
  } loader_state_e;

  function automatic int words_per_matrix(input int n);
    return n * n;
  endfunction

  localparam int DEFAULT_N = 8;
  localparam int WORDS_PER_MATRIX = words_per_matrix(DEFAULT_N);

endpackage

// File: rtl/matrix_loader_if.sv
// Stream, queue-write and array-control signals between the host side and the loader.
// The loader connects through the slave modport; the host/array side uses master.
interface matrix_loader_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  s_valid_i;
  logic                  s_ready_o;
  logic [DATA_WIDTH-1:0] s_data_i;
  logic                  s_last_i;

  logic                  west_write_enable_o;
  logic [DATA_WIDTH-1:0] west_write_data_o;
  logic                  west_write_reset_o;
  logic                  north_write_enable_o;
  logic [DATA_WIDTH-1:0] north_write_data_o;
  logic                  north_write_reset_o;

  logic                  start_matrix_mult_o;
  logic                  matrix_mult_complete_i;

  modport slave (
    input  s_valid_i, s_data_i, s_last_i, matrix_mult_complete_i,
    output s_ready_o,
    output west_write_enable_o, west_write_data_o, west_write_reset_o,
    output north_write_enable_o, north_write_data_o, north_write_reset_o,
    output start_matrix_mult_o
  );

  modport master (
    output s_valid_i, s_data_i, s_last_i, matrix_mult_complete_i,
    input  s_ready_o,
    input  west_write_enable_o, west_write_data_o, west_write_reset_o,
    input  north_write_enable_o, north_write_data_o, north_write_reset_o,
    input  start_matrix_mult_o
  );

endinterface

// File: rtl/matrix_loader_beat_counter.sv
// Modulo-MODULUS beat counter with synchronous clear; wrap pulses on the increment
// that returns the count to zero.
module loader_beat_counter #(
  parameter int MODULUS = 64,
  localparam int CW = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          wrap
);

  assign wrap = inc && (count == CW'(MODULUS - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// Loads matrix A into the west queues and matrix B into the north queues, then runs the array.
// Define MATRIX_LOADER_LAST_CHECK_EN to enable s_last_i framing checks on err_o.
module matrix_loader
  import matrix_loader_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_req_i,
  matrix_loader_if.slave  bus,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  localparam int WPM = words_per_matrix(N);
  localparam int CW  = (WPM > 1) ? $clog2(WPM) : 1;

  loader_state_e         state;
  logic                  beat;
  logic                  word_wrap;
  logic [CW-1:0]         unused_word_count;
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  seen_low;

  assign beat      = bus.s_valid_i && bus.s_ready_o;
  assign beat_data = bus.s_data_i;

  // One counter serves both load phases; its wrap marks the last word of each matrix.
  loader_beat_counter #(.MODULUS(WPM)) u_word_counter (
    .clk   (clk_i),
    .rst   (rst_i),
    .clear (state == PTR_RST),
    .inc   (beat),
    .count (unused_word_count),
    .wrap  (word_wrap)
  );

`ifndef MATRIX_LOADER_LAST_CHECK_EN
  logic unused_last;
  assign unused_last = bus.s_last_i;
  assign err_o       = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state                    <= IDLE;
      seen_low                 <= 1'b0;
      busy_o                   <= 1'b0;
      done_o                   <= 1'b0;
      bus.s_ready_o            <= 1'b0;
      bus.west_write_enable_o  <= 1'b0;
      bus.west_write_data_o    <= '0;
      bus.west_write_reset_o   <= 1'b0;
      bus.north_write_enable_o <= 1'b0;
      bus.north_write_data_o   <= '0;
      bus.north_write_reset_o  <= 1'b0;
      bus.start_matrix_mult_o  <= 1'b0;
`ifdef MATRIX_LOADER_LAST_CHECK_EN
      err_o                    <= 1'b0;
`endif
    end else begin
      bus.west_write_enable_o  <= 1'b0;
      bus.north_write_enable_o <= 1'b0;
      bus.west_write_reset_o   <= 1'b0;
      bus.north_write_reset_o  <= 1'b0;
      bus.start_matrix_mult_o  <= 1'b0;
      done_o                   <= 1'b0;

      if (beat) begin
        if (state == LOAD_WEST) begin
          bus.west_write_enable_o  <= 1'b1;
          bus.west_write_data_o    <= beat_data;
        end else begin
          bus.north_write_enable_o <= 1'b1;
          bus.north_write_data_o   <= beat_data;
        end
      end

`ifdef MATRIX_LOADER_LAST_CHECK_EN
      if (beat && (bus.s_last_i != (state == LOAD_NORTH && word_wrap))) begin
        err_o <= 1'b1;
      end
`endif

      case (state)
        // done_o high means FINISH just ended; a request in that cycle is not taken.
        IDLE: begin
          if (load_req_i && !done_o) begin
            state  <= PTR_RST;
            busy_o <= 1'b1;
          end
        end
        PTR_RST: begin
          bus.west_write_reset_o  <= 1'b1;
          bus.north_write_reset_o <= 1'b1;
          bus.s_ready_o           <= 1'b1;
          state                   <= LOAD_WEST;
`ifdef MATRIX_LOADER_LAST_CHECK_EN
          err_o                   <= 1'b0;
`endif
        end
        LOAD_WEST: begin
          if (word_wrap) state <= LOAD_NORTH;
        end
        LOAD_NORTH: begin
          if (word_wrap) begin
            state         <= START;
            bus.s_ready_o <= 1'b0;
          end
        end
        START: begin
          bus.start_matrix_mult_o <= 1'b1;
          seen_low                <= 1'b0;
          state                   <= WAIT_DONE;
        end
        // Ignore the start-pulse cycle, then require a low sample before accepting a high one.
        WAIT_DONE: begin
          if (!bus.start_matrix_mult_o) begin
            if (!bus.matrix_mult_complete_i) begin
              seen_low <= 1'b1;
            end else if (seen_low) begin
              state <= FINISH;
            end
          end
        end
        FINISH: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Randomized bench for matrix_loader (N=2) against a timeline-based reference model.
// Framing-error expectations follow MATRIX_LOADER_LAST_CHECK_EN.
module tb_matrix_loader;

  localparam int N     = 2;
  localparam int DW    = 32;
  localparam int W     = N * N;
  localparam int TOTAL = 2 * W;
`ifdef MATRIX_LOADER_LAST_CHECK_EN
  localparam bit LAST_CHECK = 1'b1;
`else
  localparam bit LAST_CHECK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_req = 1'b0;
  logic busy, done, err;

  matrix_loader_if #(.DATA_WIDTH(DW)) bus ();

  matrix_loader #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_req_i (load_req),
    .bus        (bus),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
    end
  endtask

  // Reference model: tracks when the request, final beat and completion happened and
  // derives each next-cycle output from those timestamps.
  bit            m_active = 1'b0;
  int            t_req = 0, nbeats = 0, t_final = -1, t_cmp = -1;
  bit            seen_low = 1'b0;
  bit            was_done;
  logic          e_ready = 0, e_busy = 0, e_wreset = 0, e_west_en = 0, e_north_en = 0;
  logic          e_start = 0, e_done = 0, e_err = 0;
  logic [DW-1:0] e_west_data = '0, e_north_data = '0;

  always @(posedge clk) begin
    was_done   = e_done;
    e_wreset   = 1'b0;
    e_west_en  = 1'b0;
    e_north_en = 1'b0;
    e_start    = 1'b0;
    e_done     = 1'b0;
    if (rst) begin
      m_active     = 1'b0;
      t_final      = -1;
      t_cmp        = -1;
      e_west_data  = '0;
      e_north_data = '0;
      e_err        = 1'b0;
      e_ready      = 1'b0;
      e_busy       = 1'b0;
    end else begin
      if (!m_active) begin
        if (load_req && !was_done) begin
          m_active = 1'b1;
          t_req    = cyc;
          nbeats   = 0;
          t_final  = -1;
          t_cmp    = -1;
          seen_low = 1'b0;
        end
      end else begin
        if (cyc == t_req + 1) begin
          e_wreset = 1'b1;
          e_err    = 1'b0;
        end
        if (cyc >= t_req + 2 && t_final < 0 && bus.s_valid_i) begin
          if (nbeats < W) begin
            e_west_en   = 1'b1;
            e_west_data = bus.s_data_i;
          end else begin
            e_north_en   = 1'b1;
            e_north_data = bus.s_data_i;
          end
          if (LAST_CHECK && (bus.s_last_i !== (nbeats == TOTAL - 1))) e_err = 1'b1;
          nbeats++;
          if (nbeats == TOTAL) t_final = cyc;
        end
        if (t_final >= 0 && cyc == t_final + 1) e_start = 1'b1;
        if (t_final >= 0 && cyc >= t_final + 3 && t_cmp < 0) begin
          if (!bus.matrix_mult_complete_i) seen_low = 1'b1;
          else if (seen_low) t_cmp = cyc;
        end
        if (t_cmp >= 0 && cyc == t_cmp + 1) begin
          e_done   = 1'b1;
          m_active = 1'b0;
        end
      end
      e_busy  = m_active;
      e_ready = m_active && (cyc + 1 >= t_req + 2) && (t_final < 0);
    end
    cyc++;
  end

  // Per-cycle comparison plus a monitor feeding the literal checks.
  logic [DW-1:0] west_q[$];
  logic [DW-1:0] north_q[$];
  int            done_count = 0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      check_output("s_ready",     bus.s_ready_o,            e_ready);
      check_output("busy",        busy,                     e_busy);
      check_output("done",        done,                     e_done);
      check_output("err",         err,                      e_err);
      check_output("west_reset",  bus.west_write_reset_o,   e_wreset);
      check_output("north_reset", bus.north_write_reset_o,  e_wreset);
      check_output("west_en",     bus.west_write_enable_o,  e_west_en);
      check_output("north_en",    bus.north_write_enable_o, e_north_en);
      check_output("west_data",   bus.west_write_data_o,    e_west_data);
      check_output("north_data",  bus.north_write_data_o,   e_north_data);
      check_output("start",       bus.start_matrix_mult_o,  e_start);
      if (bus.west_write_enable_o)  west_q.push_back(bus.west_write_data_o);
      if (bus.north_write_enable_o) north_q.push_back(bus.north_write_data_o);
      if (done) done_count++;
    end
  end

  // One complete load sequence; extra_reqs injects ignored requests in LOAD_NORTH,
  // WAIT_DONE and the done cycle. cmp_delay must be at least 2.
  task automatic apply_stimulus(input logic [DW-1:0] base, input int vmode, input int last_pos,
                                input int cmp_delay, input bit pre_cmp, input bit extra_reqs);
    int idx = 0;
    int budget = 0;
    int final_cyc = -1;
    int st_cyc;
    int cmp_cyc;
    bit rdy;
    bit req_sent = 1'b0;
    done_count = 0;
    bus.matrix_mult_complete_i = pre_cmp;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    while (idx < TOTAL && budget < 200) begin
      rdy = bus.s_ready_o;
      load_req = 1'b0;
      if (extra_reqs && idx == W + 1 && rdy && !req_sent) begin
        load_req = 1'b1;
        req_sent = 1'b1;
      end
      case (vmode)
        0:       bus.s_valid_i = 1'b1;
        1:       bus.s_valid_i = (budget % 2 == 0);
        default: bus.s_valid_i = 1'($urandom_range(0, 1));
      endcase
      bus.s_data_i = base + DW'(idx);
      bus.s_last_i = (idx == last_pos);
      if (bus.s_valid_i && rdy) begin
        if (idx == TOTAL - 1) final_cyc = cyc;
        idx++;
      end
      budget++;
      @(negedge clk);
    end
    bus.s_valid_i = 1'b0;
    bus.s_last_i  = 1'b0;
    load_req      = 1'b0;
    check_output("stream_accepted", idx, TOTAL);

    budget = 0;
    while (!bus.start_matrix_mult_o && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check_output("start_seen", bus.start_matrix_mult_o, 1);
    st_cyc = cyc;
    check_output("start_latency", st_cyc - final_cyc, 2);

    for (int k = 1; k < cmp_delay; k++) begin
      @(negedge clk);
      bus.matrix_mult_complete_i = 1'b0;
      load_req = extra_reqs && (k == 1);
    end
    @(negedge clk);
    load_req = 1'b0;
    bus.matrix_mult_complete_i = 1'b1;
    cmp_cyc = cyc;

    budget = 0;
    while (!done && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    check_output("done_seen", done, 1);
    check_output("done_latency", cyc - cmp_cyc, 2);
    load_req = extra_reqs;
    bus.matrix_mult_complete_i = 1'b0;
    @(negedge clk);
    load_req = 1'b0;
    repeat (3) @(negedge clk);
    check_output("done_count", done_count, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx;
    int budget;
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = '0;
    bus.s_last_i  = 1'b0;
    bus.matrix_mult_complete_i = 1'b0;

    repeat (3) @(negedge clk);
    check_output("rst_busy",  busy, 0);
    check_output("rst_ready", bus.s_ready_o, 0);
    check_output("rst_done",  done, 0);
    check_output("rst_err",   err, 0);
    check_output("rst_start", bus.start_matrix_mult_o, 0);
    check_output("rst_west_data", bus.west_write_data_o, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] basic load");
    west_q.delete();
    north_q.delete();
    apply_stimulus(32'h1, 0, TOTAL - 1, 3, 1'b0, 1'b0);
    check_output("west_count",  west_q.size(),  W);
    check_output("north_count", north_q.size(), W);
    for (int i = 0; i < W; i++) begin
      if (i < west_q.size())  check_output("west_word",  west_q[i],  32'(i + 1));
      if (i < north_q.size()) check_output("north_word", north_q[i], 32'(i + 5));
    end

    $display("[TB] backpressure");
    apply_stimulus(32'h10, 1, TOTAL - 1, 4, 1'b0, 1'b0);

    $display("[TB] completion handshake");
    apply_stimulus(32'h20, 0, TOTAL - 1, 20, 1'b1, 1'b0);

    $display("[TB] reset mid-load");
    idx = 0;
    budget = 0;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    bus.s_valid_i = 1'b1;
    while (idx < 3 && budget < 20) begin
      bus.s_data_i = 32'hA0 + DW'(idx);
      if (bus.s_ready_o) idx++;
      @(negedge clk);
      budget++;
    end
    bus.s_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_output("midrst_busy",    busy, 0);
    check_output("midrst_ready",   bus.s_ready_o, 0);
    check_output("midrst_west_en", bus.west_write_enable_o, 0);
    check_output("midrst_data",    bus.west_write_data_o, 0);
    rst = 1'b0;
    @(negedge clk);
    apply_stimulus(32'h30, 0, TOTAL - 1, 3, 1'b0, 1'b0);

    $display("[TB] ignored requests");
    apply_stimulus(32'h40, 0, TOTAL - 1, 5, 1'b0, 1'b1);
    check_output("idle_after_ignored", busy, 0);

    $display("[TB] framing");
    apply_stimulus(32'h50, 0, 4, 3, 1'b0, 1'b0);
    check_output("err_sticky", err, LAST_CHECK);
    apply_stimulus(32'h60, 0, TOTAL - 1, 3, 1'b0, 1'b0);
    check_output("err_cleared", err, 0);

    $display("[TB] randomized sequences");
    for (int r = 0; r < 8; r++) begin
      apply_stimulus($urandom, int'($urandom_range(0, 2)),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TOTAL - 1)) : TOTAL - 1,
                     int'($urandom_range(2, 8)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
